// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: captures one load/store, answers after LATENCY
// cycles with lane-aligned, sign/zero-extended data or an error strobe.
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqDatatype,
    input  logic        ReqSigned,
    output logic        ReqReady,
    output logic        RspValid,
    output logic [31:0] RspRData,
    output logic        RspErr,
    output logic        Stall
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, wdata_reg;
    logic [1:0]  dtype_reg;
    logic        signed_reg, write_reg;
    logic [31:0] rd_data_reg;
    logic [31:0] mem [DEPTH];

    logic             accept, going_resp;
    logic [31:0]      acc_addr, acc_wdata;
    logic [1:0]       acc_dtype;
    logic             acc_write, acc_err, resp_err;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_val;

    function automatic logic access_err(input logic [31:0] a, input logic [1:0] dt);
        logic bad_align;
        case (dt)
            2'b10:   bad_align = 1'b0;
            2'b01:   bad_align = a[0];
            default: bad_align = (a[1:0] != 2'b00);
        endcase
        return bad_align || (a[31:2] >= 30'(DEPTH));
    endfunction

    assign accept   = (state_reg == IDLE) && ReqValid && Rst;
    assign ReqReady = (state_reg == IDLE) && Rst;
    assign RspValid = (state_reg == RESP);
    assign Stall    = ReqValid & ~RspValid;

    // With LATENCY=1 the array is touched on the acceptance edge itself, before the
    // holding registers are loaded, so the live inputs are used while in IDLE.
    assign acc_addr  = (state_reg == IDLE) ? ReqAddr     : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? ReqWData    : wdata_reg;
    assign acc_dtype = (state_reg == IDLE) ? ReqDatatype : dtype_reg;
    assign acc_write = (state_reg == IDLE) ? ReqWrite    : write_reg;
    assign acc_err   = access_err(acc_addr, acc_dtype);
    assign mem_idx   = acc_addr[IDX_W+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = (acc_dtype == 2'b10) ? (acc_addr[1:0] == 2'(gi)) :
                                 (acc_dtype == 2'b01) ? (acc_addr[1] == 1'(gi / 2)) : 1'b1;
            assign lane_data[8*gi +: 8] = (acc_dtype == 2'b10) ? acc_wdata[7:0] :
                                          (acc_dtype == 2'b01) ? acc_wdata[8*(gi%2) +: 8] :
                                                                 acc_wdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        going_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY <= 1) begin
                        state_next = RESP;
                        going_resp = 1'b1;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                    going_resp = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            dtype_reg  <= 2'b00;
            signed_reg <= 1'b0;
            write_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg   <= ReqAddr;
                wdata_reg  <= ReqWData;
                dtype_reg  <= ReqDatatype;
                signed_reg <= ReqSigned;
                write_reg  <= ReqWrite;
            end
        end
    end

    // Storage is left out of reset so contents survive it; an aborted access never
    // reaches going_resp because reset forces the FSM back to IDLE.
    always_ff @(posedge Clk) begin
        if (going_resp && !acc_err) begin
            if (acc_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) mem[mem_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end else begin
                rd_data_reg <= mem[mem_idx];
            end
        end
    end

    assign resp_err  = access_err(addr_reg, dtype_reg);
    assign load_byte = rd_data_reg[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = rd_data_reg[{addr_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (dtype_reg)
            2'b10:   load_val = {{24{signed_reg & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{signed_reg & load_half[15]}}, load_half};
            default: load_val = rd_data_reg;
        endcase
    end

    assign RspErr   = RspValid && resp_err;
    assign RspRData = (RspValid && !write_reg && !resp_err) ? load_val : 32'd0;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance edge to response cycle, legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 1024: number of 32-bit words in the storage array.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ReqValid, input, 1 bit: the MEM-stage access request is present.
REQ-006 The block SHALL have port ReqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port ReqAddr, input, 32 bits: byte address.
REQ-008 The block SHALL have port ReqWData, input, 32 bits: store data, right-justified.
REQ-009 The block SHALL have port ReqDatatype, input, 2 bits: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
REQ-010 The block SHALL have port ReqSigned, input, 1 bit: load sign-extends when 1, zero-extends when 0.
REQ-011 The block SHALL have port ReqReady, output, 1 bit: request accepted on this edge if ReqValid is also 1.
REQ-012 The block SHALL have port RspValid, output, 1 bit: one-cycle response strobe.
REQ-013 The block SHALL have port RspRData, output, 32 bits: load result.
REQ-014 The block SHALL have port RspErr, output, 1 bit: misaligned or out-of-range access.
REQ-015 The block SHALL have port Stall, output, 1 bit: pipeline hold request to the datapath.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; ReqReady = 1 only in IDLE.
REQ-017 IDLE transition: when ReqValid=1, the edge SHALL capture addr, wdata, datatype, signed and write into holding registers, then go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-018 WAIT transition: the state SHALL go to RESP on the edge that completes LATENCY edges after the acceptance edge; a down-counter controls this.
REQ-019 RESP SHALL last exactly one cycle with RspValid=1, then return to IDLE; a back-to-back request is accepted no earlier than the following IDLE cycle.
REQ-020 Requests SHALL be ignored while in WAIT and RESP; held request fields SHALL not change during that time, even if the inputs change.
REQ-021 Lanes SHALL be little-endian: byte k = ReqAddr[1:0]; halfword lane = ReqAddr[1].
REQ-022 Stores SHALL commit on the edge entering RESP, writing only the selected lane(s) of word ReqAddr[31:2]; other bytes are preserved.
REQ-023 Loads SHALL present in RESP the selected lane, right-justified in RspRData, with upper bits sign- or zero-extended per ReqSigned; a word load returns the word unchanged.
REQ-024 For stores, RspRData SHALL be 0 in RESP.
REQ-025 Errors: a halfword with ReqAddr[0]=1, a word with ReqAddr[1:0]≠0, or ReqAddr[31:2] ≥ DEPTH SHALL produce RspErr=1 in RESP, RspRData=0, and no array write.
REQ-026 RspRData and RspErr SHALL be 0 whenever RspValid=0.
REQ-027 Stall SHALL equal ReqValid & ~RspValid, combinationally, so the MEM stage holds until the response cycle.

Reset
REQ-028 While Rst=0, outputs SHALL be: state IDLE, ReqReady=0, RspValid=0, RspRData=0, RspErr=0, counter 0; Stall still follows REQ-027.
REQ-029 Reset asserted mid-WAIT SHALL abort the access, and a pending store SHALL not be written.
REQ-030 The array SHALL not be cleared by reset.
REQ-031 ReqReady SHALL rise to 1 in the first cycle after Rst deasserts.

Verification
REQ-032 Word store, then load: store 0xDEADBEEF to 0x10; load word 0x10 with LATENCY=2 -> RspValid exactly 2 edges after acceptance, RspRData=0xDEADBEEF, Stall=1 for 2 cycles then 0.
REQ-033 Byte merge: after REQ-032, store byte 0x5A at 0x12, then load word 0x10 -> 0xDE5ABEEF; signed byte load at 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-034 Halfword: signed halfword load at 0x12 -> 0xFFFFDE5A; halfword load at 0x11 -> RspErr=1, RspRData=0.
REQ-035 Range: store to 0x1000 with DEPTH=1024 -> RspErr=1, and word 0 is unchanged on readback.
REQ-036 Reset mid-operation: store 0x11111111 to 0x20, assert Rst during WAIT, release, then load 0x20 -> prior contents returned, RspValid never asserted for the aborted store.
REQ-037 Busy-ignore: change ReqAddr/ReqWData during WAIT -> the response reflects the originally captured request, and ReqReady=0 until the cycle after RESP.
